control_pd_debug_multi_capture: RTL and testbench
=================================================

// Module: control_pd_debug_multi_capture
// PURPOSE
//  Next-generation PD debug tap. NUM_FIELDS mask/value match channels each drive per-field counter pulses.
//  An arm->trigger sequencer feeds a CAPTURE_DEPTH-entry PD history buffer, read back one 32b word at a time.
//  Sits beside the PD pipeline on the e_valid/eq_pd tap; outputs go to the CIF counter/status block.
// PARAMETERS
//  PD_WIDTH            100  width of tapped PD
//  NUM_FIELDS          4    number of match channels (>=2)
//  CAPTURE_DEPTH       8    history entries (power of 2, >=2)
//  PACKET_SIZE_OFFSET  0    LSB of byte-count field in PD
//  PACKET_SIZE_WIDTH   12   width of byte-count field
//  WIN_W               16   width of arm->trigger window counter
//  (derived) FSEL_W=$clog2(NUM_FIELDS), PTR_W=$clog2(CAPTURE_DEPTH), WSEL_W=$clog2(ceil(PD_WIDTH/32)+TS word)
// PORTS
//  clk                    in   1                    clock
//  rstn                   in   1                    reset, synchronous, active-low
//  e_valid                in   1                    PD valid
//  eq_pd                  in   PD_WIDTH             PD data
//  cfg_field_value        in   NUM_FIELDS*PD_WIDTH  match values, field i at [i*PD_WIDTH +: PD_WIDTH]
//  cfg_field_mask         in   NUM_FIELDS*PD_WIDTH  match masks, same packing
//  cfg_en                 in   4                    [0] cnt en, [1] capture en, [2] wrap mode, [3] sequence mode
//  cfg_arm_field_sel      in   FSEL_W               arm field (sequence mode)
//  cfg_trig_field_sel     in   FSEL_W               trigger field
//  cfg_window             in   WIN_W                max cycles ARMED->trigger; 0 = unlimited
//  cfg_post_count         in   PTR_W+1              PDs captured after trigger; 0 = unlimited
//  capture_trigger        in   1                    designer trigger, ORed with trigger-field match
//  rd_entry_sel           in   PTR_W                entry index, 0 = oldest
//  rd_word_sel            in   WSEL_W               32b word index within entry
//  field_cnt_inc          out  NUM_FIELDS           per-field match pulse
//  field_byte_cnt_inc     out  NUM_FIELDS           equals field_cnt_inc
//  byte_cnt_inc_amount    out  PACKET_SIZE_WIDTH    eq_pd[PACKET_SIZE_OFFSET +: PACKET_SIZE_WIDTH]
//  total_pd_cnt_inc       out  1                    e_valid & cfg_en[0]
//  capture_match_o        out  1                    pulse: PD written to buffer this cycle
//  capture_state          out  2                    FSM state
//  capture_fill           out  PTR_W+1              valid entries, saturates at CAPTURE_DEPTH
//  dbg2cif_c_debug_pd_out out  32                   selected word, registered
// BEHAVIOUR
//  - Reset: FSM IDLE, fill 0, wr_ptr 0, window/post counters 0, dbg2cif_c_debug_pd_out 0. Buffer data is not reset.
//  - Counter outputs are combinational, same cycle as e_valid: field_cnt_inc[i] = e_valid & match[i] & cfg_en[0].
//  - FSM IDLE(0)/ARMED(1)/CAPTURE(2)/DONE(3). cfg_en[1]=0 forces IDLE, fill=0, wr_ptr=0 on the next edge.
//  - IDLE, simple mode (cfg_en[3]=0): go to CAPTURE. Sequence mode: e_valid & match[arm] -> ARMED, window count cleared.
//  - A PD that matches both arm and trigger while IDLE only arms. The trigger must come on a later PD.
//  - ARMED: e_valid & (match[trig] | capture_trigger) -> CAPTURE, and that PD is written.
//  - ARMED timeout: the window counter counts clk cycles. When cfg_window!=0 and the count reaches cfg_window with no trigger -> IDLE.
//  - CAPTURE, simple mode: write on e_valid & (match[trig] | capture_trigger).
//  - CAPTURE, sequence mode: write every valid PD.
//  - Write: buf[wr_ptr]<=eq_pd, wr_ptr++ (wraps mod DEPTH), fill++ saturating, capture_match_o=1. This is one write per cycle, with no backpressure.
//  - CAPTURE->DONE when written count == cfg_post_count (nonzero).
//  - No-wrap mode (cfg_en[2]=0): also CAPTURE->DONE when fill reaches DEPTH. No write ever overwrites an entry.
//  - Wrap mode: the oldest entry is overwritten and fill stays at DEPTH.
//  - DONE: no writes. It holds until cfg_en[1] is deasserted.
//  - Readout: physical index = (wr_ptr - fill + rd_entry_sel) mod DEPTH.
//  - Readout returns 0 if rd_entry_sel >= fill. Words past PD_WIDTH are zero-padded. Latency is 1 clk.
// CONFIGURATION
//  CONTROL_PD_DEBUG_TIMESTAMP_EN defined:
//   - 32b free-running cycle counter (reset 0, wraps), stored with every entry.
//   - Readable as word index ceil(PD_WIDTH/32).
//  Undefined: no counter or storage, and that word index reads 0.
// STRUCTURE
//  - Package control_pd_debug_pkg holds:
//    - cap_state_e enum
//    - cfg_en bit-position localparams (CFG_CNT_EN=0, CFG_CAP_EN=1, CFG_WRAP=2, CFG_SEQ=3)
//    - ceil-div word-count function
//  - Sub-module control_pd_debug_field_match: one mask/value comparator, instantiated NUM_FIELDS times via generate.
// TESTING
//  - Counters: fields 0,1 masks select PD[7:0], values 0x11/0x22. Send 3 PDs with byte 0x11 and 2 with 0x22.
//    -> 3 and 2 pulses, total_pd_cnt_inc 5. With cfg_en[0]=0, no pulses.
//  - Simple no-wrap: DEPTH 8, 10 trigger matches -> 8 writes, then DONE. Entry 0 = first PD, entry 7 = eighth.
//  - Simple wrap: 10 matches -> fill 8, entry 0 = third PD, entry 7 = tenth. The FSM stays in CAPTURE.
//  - Sequence: arm=f0, trig=f1, window 5, post 3.
//    - Trigger 7 cycles after arm -> back to IDLE.
//    - Re-arm, trigger 2 cycles later -> trigger PD plus next 2 PDs captured, then DONE.
//  - Boundaries:
//    - PD matching arm and trig in IDLE -> ARMED only.
//    - rd_entry_sel >= fill -> out 0.
//    - rstn low during CAPTURE -> IDLE, fill 0 next cycle.
//    - TIMESTAMP_EN: entries read back with increasing timestamps.

Source files
------------

// File: rtl/control_pd_debug_pkg.sv
// Shared types and helpers for the PD debug tap.
// No logic, no latency.
// No flow control.
package control_pd_debug_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_e;

    localparam int CFG_CNT_EN = 0;
    localparam int CFG_CAP_EN = 1;
    localparam int CFG_WRAP   = 2;
    localparam int CFG_SEQ    = 3;

    // Number of 32b words needed to hold a field of the given width.
    function automatic int word_count(input int width);
        return (width + 31) / 32;
    endfunction

endpackage

// File: rtl/control_pd_debug_field_match.sv
// One mask/value comparator: hit when every masked PD bit equals the value bit.
// Combinational, zero latency.
// No flow control.
module control_pd_debug_field_match #(
    parameter int PD_WIDTH = 100
) (
    input  logic [PD_WIDTH-1:0] eq_pd,
    input  logic [PD_WIDTH-1:0] field_value,
    input  logic [PD_WIDTH-1:0] field_mask,
    output logic                match
);

    assign match = ~|((eq_pd ^ field_value) & field_mask);

endmodule

// File: rtl/control_pd_debug_multi_capture.sv
// PD debug tap: per-field match counter pulses plus an arm/trigger sequenced PD history buffer.
// Counter pulses combinational; capture writes on the next edge; word readout 1 clk.
// No backpressure, one write per cycle. CONTROL_PD_DEBUG_TIMESTAMP_EN adds per-entry timestamps.
module control_pd_debug_multi_capture
    import control_pd_debug_pkg::*;
#(
    parameter int PD_WIDTH           = 100,
    parameter int NUM_FIELDS         = 4,
    parameter int CAPTURE_DEPTH      = 8,
    parameter int PACKET_SIZE_OFFSET = 0,
    parameter int PACKET_SIZE_WIDTH  = 12,
    parameter int WIN_W              = 16,
    localparam int FSEL_W = $clog2(NUM_FIELDS),
    localparam int PTR_W  = $clog2(CAPTURE_DEPTH),
    localparam int WORDS  = word_count(PD_WIDTH),
    localparam int WSEL_W = $clog2(WORDS + 1)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             e_valid,
    input  logic [PD_WIDTH-1:0]              eq_pd,
    input  logic [NUM_FIELDS*PD_WIDTH-1:0]   cfg_field_value,
    input  logic [NUM_FIELDS*PD_WIDTH-1:0]   cfg_field_mask,
    input  logic [3:0]                       cfg_en,
    input  logic [FSEL_W-1:0]                cfg_arm_field_sel,
    input  logic [FSEL_W-1:0]                cfg_trig_field_sel,
    input  logic [WIN_W-1:0]                 cfg_window,
    input  logic [PTR_W:0]                   cfg_post_count,
    input  logic                             capture_trigger,
    input  logic [PTR_W-1:0]                 rd_entry_sel,
    input  logic [WSEL_W-1:0]                rd_word_sel,
    output logic [NUM_FIELDS-1:0]            field_cnt_inc,
    output logic [NUM_FIELDS-1:0]            field_byte_cnt_inc,
    output logic [PACKET_SIZE_WIDTH-1:0]     byte_cnt_inc_amount,
    output logic                             total_pd_cnt_inc,
    output logic                             capture_match_o,
    output logic [1:0]                       capture_state,
    output logic [PTR_W:0]                   capture_fill,
    output logic [31:0]                      dbg2cif_c_debug_pd_out
);

    localparam logic [PTR_W:0] FILL_MAX = (PTR_W+1)'(CAPTURE_DEPTH);

    logic [NUM_FIELDS-1:0] match;

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
        control_pd_debug_field_match #(.PD_WIDTH(PD_WIDTH)) u_match (
            .eq_pd       (eq_pd),
            .field_value (cfg_field_value[gi*PD_WIDTH +: PD_WIDTH]),
            .field_mask  (cfg_field_mask[gi*PD_WIDTH +: PD_WIDTH]),
            .match       (match[gi])
        );
    end

    logic cnt_en, cap_en, wrap_en, seq_en;
    assign cnt_en  = cfg_en[CFG_CNT_EN];
    assign cap_en  = cfg_en[CFG_CAP_EN];
    assign wrap_en = cfg_en[CFG_WRAP];
    assign seq_en  = cfg_en[CFG_SEQ];

    assign field_cnt_inc       = match & {NUM_FIELDS{e_valid & cnt_en}};
    assign field_byte_cnt_inc  = field_cnt_inc;
    assign byte_cnt_inc_amount = eq_pd[PACKET_SIZE_OFFSET +: PACKET_SIZE_WIDTH];
    assign total_pd_cnt_inc    = e_valid & cnt_en;

    cap_state_e       state;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W:0]   win_nxt;
    logic [PTR_W:0]   post_cnt, fill, fill_nxt;
    logic [PTR_W+1:0] post_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic             arm_hit, trig_hit, room, wr_en;
    logic             post_hit, full_hit, fin, win_expired;

    assign arm_hit     = e_valid & match[cfg_arm_field_sel];
    assign trig_hit    = e_valid & (match[cfg_trig_field_sel] | capture_trigger);
    assign room        = wrap_en | (fill != FILL_MAX);
    assign fill_nxt    = (fill == FILL_MAX) ? FILL_MAX : fill + (PTR_W+1)'(1);
    assign post_nxt    = {1'b0, post_cnt} + (PTR_W+2)'(1);
    assign win_nxt     = {1'b0, win_cnt} + (WIN_W+1)'(1);
    assign post_hit    = (cfg_post_count != '0) && (post_nxt == {1'b0, cfg_post_count});
    assign full_hit    = !wrap_en && (fill_nxt == FILL_MAX);
    assign fin         = wr_en && (post_hit || full_hit);
    // win_nxt is the number of ARMED cycles including this one.
    assign win_expired = (cfg_window != '0) && (win_nxt >= {1'b0, cfg_window});

    always_comb begin
        wr_en = 1'b0;
        if (cap_en && room) begin
            case (state)
                CAP_ARMED:   wr_en = trig_hit;
                CAP_CAPTURE: wr_en = seq_en ? e_valid : trig_hit;
                default:     wr_en = 1'b0;
            endcase
        end
    end

    assign capture_match_o = wr_en;
    assign capture_state   = state;
    assign capture_fill    = fill;

    always_ff @(posedge clk) begin
        if (!rstn || !cap_en) begin
            state    <= CAP_IDLE;
            fill     <= '0;
            wr_ptr   <= '0;
            win_cnt  <= '0;
            post_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fill     <= fill_nxt;
                post_cnt <= post_nxt[PTR_W:0];
            end
            case (state)
                CAP_IDLE: begin
                    if (!seq_en) begin
                        state    <= CAP_CAPTURE;
                        post_cnt <= '0;
                    end else if (arm_hit) begin
                        state    <= CAP_ARMED;
                        win_cnt  <= '0;
                        post_cnt <= '0;
                    end
                end
                CAP_ARMED: begin
                    if (trig_hit)
                        state <= (fin || !room) ? CAP_DONE : CAP_CAPTURE;
                    else if (win_expired)
                        state <= CAP_IDLE;
                    else
                        win_cnt <= win_nxt[WIN_W-1:0];
                end
                CAP_CAPTURE: begin
                    if (fin || !room)
                        state <= CAP_DONE;
                end
                default: ;
            endcase
        end
    end

    logic [PD_WIDTH-1:0] pd_buf [CAPTURE_DEPTH];

    always_ff @(posedge clk) begin
        if (rstn && wr_en)
            pd_buf[wr_ptr] <= eq_pd;
    end

    logic [PTR_W-1:0]    rd_phys;
    logic                rd_hit;
    logic [WORDS*32-1:0] rd_pad;
    logic [31:0]         ts_word, rd_word;

    // Entry 0 is the oldest still held.
    assign rd_phys = wr_ptr - fill[PTR_W-1:0] + rd_entry_sel;
    assign rd_hit  = {1'b0, rd_entry_sel} < fill;

`ifdef CONTROL_PD_DEBUG_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_buf [CAPTURE_DEPTH];

    always_ff @(posedge clk) begin
        if (!rstn)
            ts_cnt <= '0;
        else
            ts_cnt <= ts_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_en)
            ts_buf[wr_ptr] <= ts_cnt;
    end

    assign ts_word = ts_buf[rd_phys];
`else
    assign ts_word = '0;
`endif

    always_comb begin
        rd_pad = '0;
        rd_pad[PD_WIDTH-1:0] = pd_buf[rd_phys];
        rd_word = '0;
        if (rd_hit) begin
            for (int w = 0; w < WORDS; w++) begin
                if (rd_word_sel == WSEL_W'(w))
                    rd_word = rd_pad[w*32 +: 32];
            end
            if (rd_word_sel == WSEL_W'(WORDS))
                rd_word = ts_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            dbg2cif_c_debug_pd_out <= '0;
        else
            dbg2cif_c_debug_pd_out <= rd_word;
    end

endmodule

// File: tb/tb_control_pd_debug_multi_capture.sv
// Randomized bench for the PD debug tap against a queue-based history model.
module tb_control_pd_debug_multi_capture;
    import control_pd_debug_pkg::*;

    localparam int PDW = 100, NF = 4, DEPTH = 8, WW = 16;
    localparam int FSW = 2, PW = 3, WSW = 3, WORDS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn, e_valid, capture_trigger;
    logic [PDW-1:0]    eq_pd;
    logic [NF*PDW-1:0] cfg_field_value, cfg_field_mask;
    logic [3:0]        cfg_en;
    logic [FSW-1:0]    arm_sel, trig_sel;
    logic [WW-1:0]     cfg_window;
    logic [PW:0]       cfg_post_count;
    logic [PW-1:0]     rd_entry_sel;
    logic [WSW-1:0]    rd_word_sel;
    logic [NF-1:0]     field_cnt_inc, field_byte_cnt_inc;
    logic [11:0]       byte_cnt_inc_amount;
    logic              total_pd_cnt_inc, capture_match_o;
    logic [1:0]        capture_state;
    logic [PW:0]       capture_fill;
    logic [31:0]       dbg_out;

    control_pd_debug_multi_capture dut (
        .clk(clk), .rstn(rstn), .e_valid(e_valid), .eq_pd(eq_pd),
        .cfg_field_value(cfg_field_value), .cfg_field_mask(cfg_field_mask),
        .cfg_en(cfg_en), .cfg_arm_field_sel(arm_sel), .cfg_trig_field_sel(trig_sel),
        .cfg_window(cfg_window), .cfg_post_count(cfg_post_count),
        .capture_trigger(capture_trigger), .rd_entry_sel(rd_entry_sel), .rd_word_sel(rd_word_sel),
        .field_cnt_inc(field_cnt_inc), .field_byte_cnt_inc(field_byte_cnt_inc),
        .byte_cnt_inc_amount(byte_cnt_inc_amount), .total_pd_cnt_inc(total_pd_cnt_inc),
        .capture_match_o(capture_match_o), .capture_state(capture_state),
        .capture_fill(capture_fill), .dbg2cif_c_debug_pd_out(dbg_out)
    );

    int n_checks = 0, n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: captured history as a queue, oldest first.
    typedef struct packed { logic [PDW-1:0] pd; logic [31:0] ts; } entry_t;
    entry_t      hist[$];
    int          m_state, m_written, m_age;
    logic [31:0] m_ts;
    int          t_f0, t_f1, t_tot, t_wr;
    logic [PDW-1:0] sent[$];

    function automatic logic [31:0] model_word(input int e, input int w);
        logic [127:0] t;
        if (e >= hist.size()) return 32'h0;
        t = '0;
        t[PDW-1:0] = hist[e].pd;
        if (w < WORDS) return t[w*32 +: 32];
`ifdef CONTROL_PD_DEBUG_TIMESTAMP_EN
        if (w == WORDS) return hist[e].ts;
`endif
        return 32'h0;
    endfunction

    task automatic tick();
        logic [NF-1:0] m;
        logic [31:0]   exp_rd;
        bit            trig, wr, room, active, seq, wrap;
        entry_t        ent;
        #2;
        for (int i = 0; i < NF; i++)
            m[i] = ((eq_pd ^ cfg_field_value[i*PDW +: PDW]) & cfg_field_mask[i*PDW +: PDW]) == '0;
        check_eq("field_cnt_inc", field_cnt_inc, (e_valid && cfg_en[0]) ? m : '0);
        check_eq("field_byte_cnt_inc", field_byte_cnt_inc, (e_valid && cfg_en[0]) ? m : '0);
        check_eq("byte_amount", byte_cnt_inc_amount, eq_pd[11:0]);
        check_eq("total_pd_cnt_inc", total_pd_cnt_inc, e_valid && cfg_en[0]);
        t_f0 += int'(field_cnt_inc[0]); t_f1 += int'(field_cnt_inc[1]);
        t_tot += int'(total_pd_cnt_inc); t_wr += int'(capture_match_o);
        exp_rd = rstn ? model_word(int'(rd_entry_sel), int'(rd_word_sel)) : 32'h0;

        seq = cfg_en[3]; wrap = cfg_en[2];
        trig = e_valid && (m[trig_sel] || capture_trigger);
        room = wrap || hist.size() < DEPTH;
        wr = 0;
        active = (m_state == 1 || m_state == 2);
        if (!cfg_en[1]) begin
            m_state = 0;
            hist.delete();
        end else begin
            case (m_state)
                0: if (!seq) begin m_state = 2; m_written = 0; end
                   else if (e_valid && m[arm_sel]) begin m_state = 1; m_age = 0; m_written = 0; end
                1: begin
                    m_age++;
                    if (trig) begin wr = room; m_state = 2; end
                    else if (cfg_window != 0 && m_age >= int'(cfg_window)) m_state = 0;
                end
                2: wr = room && (seq ? e_valid : trig);
                default: ;
            endcase
        end
        check_eq("capture_match_o", capture_match_o, wr);
        if (wr) begin
            ent.pd = eq_pd; ent.ts = m_ts;
            hist.push_back(ent);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            m_written++;
        end
        if (active && m_state == 2 &&
            ((cfg_post_count != 0 && m_written == int'(cfg_post_count)) || (!wrap && hist.size() == DEPTH)))
            m_state = 3;
        if (!rstn) begin
            m_state = 0;
            hist.delete();
        end
        m_ts = rstn ? m_ts + 32'd1 : 32'h0;

        @(posedge clk);
        #1;
        check_eq("capture_state", capture_state, m_state);
        check_eq("capture_fill", capture_fill, hist.size());
        check_eq("debug_pd_out", dbg_out, exp_rd);
    endtask

    task automatic drive(input bit v, input logic [7:0] b, input bit ct);
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        r[7:0] = b;
        e_valid = v; eq_pd = r[PDW-1:0]; capture_trigger = ct;
        tick();
    endtask

    task automatic rd(input int e, input int w);
        rd_entry_sel = PW'(e); rd_word_sel = WSW'(w);
        drive(0, 8'h55, 0);
    endtask

    task automatic restart(input logic [3:0] en);
        cfg_en = 4'b0000;
        drive(0, 8'h55, 0);
        cfg_en = en;
        drive(0, 8'h55, 0);
    endtask

    initial begin
        logic [7:0] bl[5];
        logic [7:0] tmp;
        logic [31:0] prev_ts;
        bl[0] = 8'h11; bl[1] = 8'h22; bl[2] = 8'h33; bl[3] = 8'h44; bl[4] = 8'h55;
        rstn = 0; e_valid = 0; eq_pd = '0; capture_trigger = 0;
        cfg_field_value = '0; cfg_field_mask = '0;
        for (int i = 0; i < NF; i++) begin
            cfg_field_mask[i*PDW +: 8]  = 8'hFF;
            cfg_field_value[i*PDW +: 8] = bl[i];
        end
        cfg_en = 0; arm_sel = 0; trig_sel = 1; cfg_window = 0; cfg_post_count = 0;
        rd_entry_sel = 0; rd_word_sel = 0;
        m_state = 0; m_written = 0; m_age = 0; m_ts = 0;

        repeat (2) drive(0, 8'h55, 0);
        check_eq("rst_state", capture_state, 2'd0);
        check_eq("rst_fill", capture_fill, 0);
        check_eq("rst_out", dbg_out, 0);
        rstn = 1;

        // Counters: three 0x11 and two 0x22 PDs in random order with gaps.
        cfg_en = 4'b0001;
        t_f0 = 0; t_f1 = 0; t_tot = 0;
        bl[0] = 8'h11; bl[1] = 8'h11; bl[2] = 8'h11; bl[3] = 8'h22; bl[4] = 8'h22;
        for (int i = 0; i < 5; i++) begin
            int j = $urandom_range(0, 4);
            tmp = bl[i]; bl[i] = bl[j]; bl[j] = tmp;
        end
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 2)) drive(0, 8'h11, 0);
            drive(1, bl[i], 0);
        end
        check_eq("cnt_f0", t_f0, 3);
        check_eq("cnt_f1", t_f1, 2);
        check_eq("cnt_total", t_tot, 5);
        cfg_en = 4'b0000;
        t_f0 = 0; t_f1 = 0; t_tot = 0;
        for (int i = 0; i < 5; i++) drive(1, bl[i], 0);
        check_eq("cnt_disabled", t_f0 + t_f1 + t_tot, 0);

        // Simple mode, no wrap: ten triggers, only eight land.
        bl[0] = 8'h11; bl[1] = 8'h22; bl[2] = 8'h33; bl[3] = 8'h44; bl[4] = 8'h55;
        trig_sel = 1;
        restart(4'b0011);
        sent.delete(); t_wr = 0;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) drive(1, bl[$urandom_range(2, 4)], 0);
            drive(1, 8'h22, 0);
            sent.push_back(eq_pd);
        end
        check_eq("nowrap_writes", t_wr, 8);
        check_eq("nowrap_done", capture_state, 2'd3);
        rd(0, 0); check_eq("nowrap_e0", dbg_out, sent[0][31:0]);
        rd(7, 3); check_eq("nowrap_e7_w3", dbg_out, {28'h0, sent[7][99:96]});
        rd(3, 5); check_eq("nowrap_word_oob", dbg_out, 0);
`ifdef CONTROL_PD_DEBUG_TIMESTAMP_EN
        rd(0, WORDS); prev_ts = dbg_out;
        for (int e = 1; e < DEPTH; e++) begin
            rd(e, WORDS);
            check_eq("ts_increasing", dbg_out > prev_ts, 1);
            prev_ts = dbg_out;
        end
`else
        prev_ts = 0;
        rd(2, WORDS); check_eq("ts_word_zero", dbg_out, prev_ts);
`endif

        // Simple mode, wrap: the two oldest are overwritten.
        restart(4'b0111);
        sent.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'h22, 0);
            sent.push_back(eq_pd);
        end
        check_eq("wrap_fill", capture_fill, 8);
        check_eq("wrap_state", capture_state, 2'd2);
        rd(0, 0); check_eq("wrap_e0", dbg_out, sent[2][31:0]);
        rd(7, 1); check_eq("wrap_e7", dbg_out, sent[9][63:32]);

        // Sequence mode: late trigger times out, prompt trigger captures post_count PDs.
        arm_sel = 0; trig_sel = 1; cfg_window = 5; cfg_post_count = 3;
        restart(4'b1011);
        t_wr = 0;
        drive(1, 8'h11, 0);
        check_eq("seq_armed", capture_state, 2'd1);
        repeat (6) drive(0, 8'h55, 0);
        drive(1, 8'h22, 0);
        check_eq("seq_timeout", capture_state, 2'd0);
        check_eq("seq_timeout_nowr", t_wr, 0);
        sent.delete();
        drive(1, 8'h11, 0);
        drive(0, 8'h55, 0);
        drive(1, 8'h22, 0); sent.push_back(eq_pd);
        check_eq("seq_capture", capture_state, 2'd2);
        drive(1, 8'h55, 0); sent.push_back(eq_pd);
        drive(1, 8'h33, 0); sent.push_back(eq_pd);
        check_eq("seq_done", capture_state, 2'd3);
        drive(1, 8'h22, 0);
        check_eq("seq_fill", capture_fill, 3);
        rd(0, 0); check_eq("seq_e0", dbg_out, sent[0][31:0]);
        rd(2, 2); check_eq("seq_e2", dbg_out, sent[2][95:64]);
        rd(3, 0); check_eq("seq_beyond_fill", dbg_out, 0);

        // One PD hitting both arm and trigger only arms.
        trig_sel = 0; cfg_window = 0; cfg_post_count = 0;
        restart(4'b1011);
        drive(1, 8'h11, 0);
        check_eq("both_armed_only", capture_state, 2'd1);
        check_eq("both_no_write", capture_fill, 0);
        drive(1, 8'h11, 0);
        check_eq("both_then_capture", capture_fill, 1);

        // Reset while capturing.
        rstn = 0;
        drive(1, 8'h11, 0);
        check_eq("rst_mid_state", capture_state, 2'd0);
        check_eq("rst_mid_fill", capture_fill, 0);
        rstn = 1;

        // Random configurations and traffic.
        for (int s = 0; s < 10; s++) begin
            arm_sel = FSW'($urandom_range(0, 3));
            trig_sel = FSW'($urandom_range(0, 3));
            cfg_window = WW'($urandom_range(0, 6));
            cfg_post_count = (PW+1)'($urandom_range(0, 5));
            restart({$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 1) == 1});
            for (int c = 0; c < 40; c++) begin
                rstn = ($urandom_range(0, 63) != 0);
                rd_entry_sel = PW'($urandom_range(0, 7));
                rd_word_sel = WSW'($urandom_range(0, 7));
                drive($urandom_range(0, 3) != 0, bl[$urandom_range(0, 4)], $urandom_range(0, 7) == 0);
            end
            rstn = 1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
